// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg: shared state encoding and counter sizing for the serial add/sub unit
package serial_addsub_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int clog2(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/serial_addsub_acc_full_adder_cell.sv
// full_adder_cell: one-bit combinational full adder, chained ripple-style per digit
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_addsub_acc.sv
// serial_addsub_acc: multi-cycle add/subtract/accumulate, STEP bits per cycle, LSB first
module serial_addsub_acc
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int STEP = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic sub,
  input  logic acc_en,
  output logic busy,
  output logic done,
  output logic [WIDTH-1:0] sum,
  output logic cout,
  output logic ovf
);
  localparam int N = WIDTH / STEP;
  localparam int CW = clog2(N);
  if (WIDTH < 2 || WIDTH % STEP != 0) begin : g_bad_params
    $error("serial_addsub_acc: WIDTH must be >= 2 and a multiple of STEP");
  end
  state_t state, state_n;
  logic [WIDTH-1:0] opa, opb, psum, psum_n;
  logic [CW-1:0] cnt;
  logic carry, last, accept;
  logic [STEP:0] c;
  logic [STEP-1:0] s;
  assign busy = state == RUN;
  assign done = state == DONE;
  assign last = cnt == CW'(N - 1);
  assign accept = start && state != RUN;
  assign c[0] = carry;
  for (genvar i = 0; i < STEP; i++) begin : g_fa
    full_adder_cell u_fa (.a(opa[i]), .b(opb[i]), .cin(c[i]), .s(s[i]), .cout(c[i+1]));
  end
  assign psum_n = (WIDTH'(s) << (WIDTH - STEP)) | (psum >> STEP);
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // next state: RUN runs N digits, otherwise start launches a new operation
  always_comb begin
    state_n = IDLE;
    if (state == RUN) state_n = last ? DONE : RUN;
    else if (start) state_n = RUN;
  end
  // operand capture, digit-serial datapath and result registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      opa <= '0;
      opb <= '0;
      psum <= '0;
      carry <= 1'b0;
      cnt <= '0;
      sum <= '0;
      cout <= 1'b0;
      ovf <= 1'b0;
    end else if (accept) begin
      opa <= acc_en ? sum : a;
      opb <= sub ? ~b : b;
      carry <= sub;
      cnt <= '0;
    end else if (state == RUN) begin
      opa <= opa >> STEP;
      opb <= opb >> STEP;
      carry <= c[STEP];
      cnt <= cnt + CW'(1);
      psum <= psum_n;
      if (last) begin
        sum <= psum_n;
        cout <= c[STEP];
        ovf <= c[STEP-1] ^ c[STEP];
      end
    end
endmodule

// File: tb/tb_serial_addsub_acc.sv
// tb_serial_addsub_acc: directed table plus corner sequences and random checks against a word-level model
module tb_serial_addsub_acc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start4 = 1'b0, sub4 = 1'b0, acc4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic busy4, done4, cout4, ovf4;
  logic [3:0] sum4;
  logic start8 = 1'b0, sub8 = 1'b0, acc8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic busy82, done82, cout82, ovf82, busy84, done84, cout84, ovf84;
  logic [7:0] sum82, sum84;
  logic [7:0] m8 = '0;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  serial_addsub_acc #(.WIDTH(4), .STEP(1)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .sub(sub4), .acc_en(acc4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
  );
  serial_addsub_acc #(.WIDTH(8), .STEP(2)) dut82 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .sub(sub8), .acc_en(acc8),
    .busy(busy82), .done(done82), .sum(sum82), .cout(cout82), .ovf(ovf82)
  );
  serial_addsub_acc #(.WIDTH(8), .STEP(4)) dut84 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .sub(sub8), .acc_en(acc8),
    .busy(busy84), .done(done84), .sum(sum84), .cout(cout84), .ovf(ovf84)
  );
  typedef struct {
    logic [3:0] a, b;
    logic sub, acc;
    logic [3:0] s;
    logic c, o;
  } vec_t;
  vec_t v[11];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic run4(input logic [3:0] ia, input logic [3:0] ib, input logic isub, input logic iacc,
                      input logic [3:0] es, input logic ec, input logic eo, input bit mess, input string n);
    int cyc;
    a4 = ia; b4 = ib; sub4 = isub; acc4 = iacc; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = mess;
    if (mess) begin
      a4 = ~ia; b4 = ~ib; sub4 = ~isub; acc4 = ~iacc;
    end
    chk({n, " busy after accept"}, busy4, 1);
    cyc = 0;
    while (!done4 && cyc < 12) begin
      @(posedge clk); #1;
      start4 = 1'b0;
      cyc++;
    end
    chk({n, " latency"}, cyc, 4);
    chk({n, " sum"}, sum4, es);
    chk({n, " cout"}, cout4, ec);
    chk({n, " ovf"}, ovf4, eo);
    chk({n, " busy at done"}, busy4, 0);
    @(posedge clk); #1;
    chk({n, " done drops"}, done4, 0);
    chk({n, " idle after done"}, busy4, 0);
  endtask
  task automatic run8(input logic [7:0] ia, input logic [7:0] ib, input logic isub, input logic iacc, input string n);
    logic [8:0] full;
    logic [7:0] oa, ob, es, s2, s4;
    logic eo, c2, c4, o2, o4;
    int l2, l4;
    oa = iacc ? m8 : ia;
    ob = isub ? ~ib : ib;
    full = {1'b0, oa} + {1'b0, ob} + 9'(isub);
    es = full[7:0];
    eo = (oa[7] == ob[7]) && (es[7] != oa[7]);
    a8 = ia; b8 = ib; sub8 = isub; acc8 = iacc; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    l2 = -1; l4 = -1;
    s2 = 'x; s4 = 'x; c2 = 'x; c4 = 'x; o2 = 'x; o4 = 'x;
    for (int cyc = 1; cyc <= 12 && (l2 < 0 || l4 < 0); cyc++) begin
      @(posedge clk); #1;
      if (done82 && l2 < 0) begin l2 = cyc; s2 = sum82; c2 = cout82; o2 = ovf82; end
      if (done84 && l4 < 0) begin l4 = cyc; s4 = sum84; c4 = cout84; o4 = ovf84; end
    end
    chk({n, " step2 latency"}, l2, 4);
    chk({n, " step2 sum"}, s2, es);
    chk({n, " step2 cout"}, c2, full[8]);
    chk({n, " step2 ovf"}, o2, eo);
    chk({n, " step4 latency"}, l4, 2);
    chk({n, " step4 sum"}, s4, es);
    chk({n, " step4 cout"}, c4, full[8]);
    chk({n, " step4 ovf"}, o4, eo);
    m8 = es;
    @(posedge clk); #1;
  endtask
  initial begin
    int cyc, dn;
    v[0]  = '{4'h7, 4'h9, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0};
    v[1]  = '{4'h5, 4'h3, 1'b0, 1'b0, 4'h8, 1'b0, 1'b1};
    v[2]  = '{4'h0, 4'h8, 1'b0, 1'b1, 4'h0, 1'b1, 1'b1};
    v[3]  = '{4'h3, 4'h5, 1'b1, 1'b0, 4'hE, 1'b0, 1'b0};
    v[4]  = '{4'h8, 4'h1, 1'b1, 1'b0, 4'h7, 1'b1, 1'b1};
    v[5]  = '{4'h0, 4'h2, 1'b1, 1'b1, 4'h5, 1'b1, 1'b0};
    v[6]  = '{4'h0, 4'h7, 1'b0, 1'b1, 4'hC, 1'b0, 1'b1};
    v[7]  = '{4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0};
    v[8]  = '{4'hF, 4'hF, 1'b0, 1'b0, 4'hE, 1'b1, 1'b0};
    v[9]  = '{4'h7, 4'h8, 1'b1, 1'b0, 4'hF, 1'b0, 1'b1};
    v[10] = '{4'h0, 4'h1, 1'b0, 1'b1, 4'h0, 1'b1, 1'b0};
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", busy4, 0);
    chk("reset done", done4, 0);
    chk("reset sum", sum4, 0);
    chk("reset cout", cout4, 0);
    chk("reset ovf", ovf4, 0);
    chk("reset sum8", {sum84, sum82}, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 11; i++)
      run4(v[i].a, v[i].b, v[i].sub, v[i].acc, v[i].s, v[i].c, v[i].o, 1'b0, $sformatf("vec%0d", i));
    run4(4'h2, 4'h3, 1'b0, 1'b0, 4'h5, 1'b0, 1'b0, 1'b1, "ignore mid-run");
    a4 = 4'h1; b4 = 4'h1; sub4 = 1'b0; acc4 = 1'b0; start4 = 1'b1;
    @(posedge clk); #1;
    a4 = 4'h6; b4 = 4'h1; sub4 = 1'b1;
    cyc = 0;
    while (!done4 && cyc < 12) begin @(posedge clk); #1; cyc++; end
    chk("b2b first latency", cyc, 4);
    chk("b2b first sum", sum4, 4'h2);
    @(posedge clk); #1;
    start4 = 1'b0;
    chk("b2b done drops", done4, 0);
    chk("b2b no idle gap", busy4, 1);
    cyc = 0;
    while (!done4 && cyc < 12) begin @(posedge clk); #1; cyc++; end
    chk("b2b second latency", cyc, 4);
    chk("b2b second sum", sum4, 4'h5);
    chk("b2b second cout", cout4, 1);
    chk("b2b second ovf", ovf4, 0);
    @(posedge clk); #1;
    a4 = 4'h7; b4 = 4'h1; sub4 = 1'b0; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    chk("async rst busy", busy4, 0);
    chk("async rst done", done4, 0);
    chk("async rst sum", sum4, 0);
    chk("async rst cout", cout4, 0);
    chk("async rst ovf", ovf4, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    dn = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done4 || busy4) dn++;
    end
    chk("no done after abort", dn, 0);
    run4(4'h1, 4'h2, 1'b0, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0, "after abort");
    run8(8'hFF, 8'h01, 1'b0, 1'b0, "ff plus 01");
    for (int i = 0; i < 1000; i++)
      run8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
